// File: rtl/vec_add_checker.sv
// vec_add_checker: LFSR-driven stimulus and latency-matched lane-wise a+b golden compare for vector adders.
// Define VEC_CHECK_STOP_ON_FAIL_EN to halt on the first mismatching vector.
module vec_add_checker #(
    parameter int          LANES   = 4,
    parameter int          W       = 8,
    parameter int          NUM_VEC = 16,
    parameter int          LATENCY = 0,
    parameter logic [31:0] SEED    = 32'hACE1_0001
) (
    input  logic               clock,
    input  logic               reset,
    output logic [LANES*W-1:0] a,
    output logic [LANES*W-1:0] b,
    input  logic [LANES*W-1:0] y,
    output logic               fail,
    output logic               finish,
    output logic [15:0]        err_count
);
    typedef enum logic [1:0] {IDLE, DRIVE, DRAIN, DONE} state_t;
    localparam logic [15:0] NV   = 16'(NUM_VEC);
    localparam logic [31:0] TAPS = 32'h8020_0003;
    function automatic logic [LANES*W-1:0] spread(input logic [31:0] l, input int off);
        logic [LANES*W-1:0] v;
        v = '0;
        for (int i = 0; i < LANES; i++) v[i*W +: W] = W'({l, l} >> ((i*W + off) % 32));
        return v;
    endfunction
    function automatic logic [LANES*W-1:0] lane_add(input logic [LANES*W-1:0] x, input logic [LANES*W-1:0] z);
        logic [LANES*W-1:0] v;
        v = '0;
        for (int i = 0; i < LANES; i++) v[i*W +: W] = x[i*W +: W] + z[i*W +: W];
        return v;
    endfunction
    state_t              state;
    logic [31:0]         lfsr;
    logic [15:0]         idx;
    logic [LATENCY:0]    vld, lst;
    logic [LANES*W-1:0]  expq [LATENCY+1];
    logic [LANES*W-1:0]  na, nb;
    logic                chk, mis, fin, stop, drive;
    always_comb begin
        na    = spread(lfsr, 0);
        nb    = spread(~lfsr, W/2);
        chk   = vld[LATENCY] && state != DONE;
        mis   = chk && (y !== expq[LATENCY]);
        fin   = chk && lst[LATENCY];
`ifdef VEC_CHECK_STOP_ON_FAIL_EN
        stop  = mis;
`else
        stop  = 1'b0;
`endif
        drive = (state == IDLE || state == DRIVE) && idx < NV && !stop;
    end
    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= IDLE;
            a         <= '0;
            b         <= '0;
            fail      <= 1'b0;
            finish    <= 1'b0;
            err_count <= '0;
            idx       <= '0;
            lfsr      <= SEED;
            vld       <= '0;
            lst       <= '0;
            for (int j = 0; j <= LATENCY; j++) expq[j] <= '0;
        end else begin
            if (drive) begin
                a     <= na;
                b     <= nb;
                lfsr  <= {1'b0, lfsr[31:1]} ^ ({32{lfsr[0]}} & TAPS);
                idx   <= idx + 16'd1;
                state <= DRIVE;
            end else if (state == DRIVE) begin
                state <= DRAIN;
            end
            // the final compare may land on the same edge as the last drive/drain step and wins
            if (fin || stop) begin
                state  <= DONE;
                finish <= 1'b1;
            end
            if (mis) begin
                fail <= 1'b1;
                if (err_count != 16'hFFFF) err_count <= err_count + 16'd1;
            end
            vld[0]  <= drive;
            lst[0]  <= drive && idx == NV - 16'd1;
            expq[0] <= lane_add(na, nb);
            for (int j = 1; j <= LATENCY; j++) begin
                vld[j]  <= vld[j-1];
                lst[j]  <= lst[j-1];
                expq[j] <= expq[j-1];
            end
        end
    end
endmodule
